// File: rtl/exwb_pkg.sv
// Shared opcode encodings and helpers for the execute/writeback stage.
package exwb_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_ADDI = 3'b011;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Sign-extends the low w bits of v to 64 bits; callers truncate to their width.
    function automatic logic [63:0] sext(input logic [63:0] v, input int w);
        logic signed [63:0] t;
        t = $signed(v << (64 - w));
        return $unsigned(t >>> (64 - w));
    endfunction

endpackage

// File: rtl/exwb_sched_pipe_lat_pipe.sv
// Fixed-depth result pipeline carrying {valid, rd, data}; reset drops everything in flight.
module lat_pipe #(
    parameter int DEPTH = 1,
    parameter int RW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid_i,
    input  logic [RW-1:0] in_rd_i,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    output logic [RW-1:0] out_rd_o,
    output logic [DW-1:0] out_data_o
);

    logic [DEPTH-1:0] v_q;
    logic [RW-1:0]    rd_q [DEPTH];
    logic [DW-1:0]    d_q  [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i] <= '0;
                d_q[i]  <= '0;
            end
        end else begin
            v_q[0]  <= in_valid_i;
            rd_q[0] <= in_rd_i;
            d_q[0]  <= in_data_i;
            for (int i = 1; i < DEPTH; i++) begin
                v_q[i]  <= v_q[i-1];
                rd_q[i] <= rd_q[i-1];
                d_q[i]  <= d_q[i-1];
            end
        end
    end

    assign out_valid_o = v_q[DEPTH-1];
    assign out_rd_o    = rd_q[DEPTH-1];
    assign out_data_o  = d_q[DEPTH-1];

endmodule

// File: rtl/exwb_sched_pipe.sv
// Execute/writeback stage: ADD/ADDI/MUL pipelines, RAW/WAW scoreboard, writeback slot ring.
// Build option EXWB_BYPASS_EN forwards the current writeback into operand reads and hazard checks.
module exwb_sched_pipe
    import exwb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NREG    = 32,
    parameter int IMM_W   = 12,
    parameter int ADD_LAT = 1,
    parameter int MUL_LAT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 opcode,
    input  logic [idx_w(NREG)-1:0]     rs1,
    input  logic [idx_w(NREG)-1:0]     rs2,
    input  logic [idx_w(NREG)-1:0]     rd,
    input  logic [IMM_W-1:0]           imm,
    output logic                       wb_valid,
    output logic [idx_w(NREG)-1:0]     wb_rd,
    output logic [WIDTH-1:0]           wb_data,
    output logic                       busy,
    output logic                       illegal_op,
    input  logic [idx_w(NREG)-1:0]     dbg_addr,
    output logic [WIDTH-1:0]           dbg_data
);

    localparam int RW = idx_w(NREG);

    logic [WIDTH-1:0]   rf_q [NREG];
    logic [NREG-1:0]    pend_q, pend_d, pend_eff, wb_clr;
    // slot_q[k]: a writeback is booked for the cycle k edges from now (k=0 is this cycle)
    logic [MUL_LAT-1:0] slot_q, slot_d;
    logic [MUL_LAT:0]   slot_ext;
    logic               run_q, ill_q;

    logic is_add, is_mul, is_addi, uses_rs1, uses_rs2, writes;
    logic slot_hit, stall, acc, add_push, mul_push;
    logic [WIDTH-1:0] op_a, op_b, imm_ext, add_res, mul_res;
    logic             a_v, m_v;
    logic [RW-1:0]    a_rd, m_rd;
    logic [WIDTH-1:0] a_d, m_d;

    assign is_add   = (opcode == OP_ADD);
    assign is_mul   = (opcode == OP_MUL);
    assign is_addi  = (opcode == OP_ADDI);
    assign uses_rs1 = is_add | is_mul | is_addi;
    assign uses_rs2 = is_add | is_mul;
    assign writes   = uses_rs1 & (rd != '0);

    always_comb begin
        wb_clr = '0;
        if (wb_valid) wb_clr[wb_rd] = 1'b1;
`ifdef EXWB_BYPASS_EN
        pend_eff = pend_q & ~wb_clr;
`else
        pend_eff = pend_q;
`endif
        // MUL never collides: nothing is ever booked MUL_LAT cycles out before this edge
        slot_ext = {1'b0, slot_q};
        slot_hit = (is_add | is_addi) & writes & slot_ext[ADD_LAT];
        stall    = (uses_rs1 & pend_eff[rs1]) | (uses_rs2 & pend_eff[rs2])
                 | (writes & pend_eff[rd]) | slot_hit;
        in_ready = run_q & ~stall;
    end

    always_comb begin
        op_a = (rs1 == '0) ? '0 : rf_q[rs1];
        op_b = (rs2 == '0) ? '0 : rf_q[rs2];
`ifdef EXWB_BYPASS_EN
        if (wb_valid && (wb_rd == rs1) && (rs1 != '0)) op_a = wb_data;
        if (wb_valid && (wb_rd == rs2) && (rs2 != '0)) op_b = wb_data;
`endif
    end

    assign imm_ext = WIDTH'(sext(64'(imm), IMM_W));
    assign add_res = op_a + (is_addi ? imm_ext : op_b);
    assign mul_res = op_a * op_b;

    assign acc      = in_valid & in_ready;
    assign add_push = acc & writes & (is_add | is_addi);
    assign mul_push = acc & writes & is_mul;

    lat_pipe #(.DEPTH(ADD_LAT), .RW(RW), .DW(WIDTH)) u_add_pipe (
        .clk(clk), .rst(rst),
        .in_valid_i(add_push), .in_rd_i(rd), .in_data_i(add_res),
        .out_valid_o(a_v), .out_rd_o(a_rd), .out_data_o(a_d)
    );

    lat_pipe #(.DEPTH(MUL_LAT), .RW(RW), .DW(WIDTH)) u_mul_pipe (
        .clk(clk), .rst(rst),
        .in_valid_i(mul_push), .in_rd_i(rd), .in_data_i(mul_res),
        .out_valid_o(m_v), .out_rd_o(m_rd), .out_data_o(m_d)
    );

    always_comb begin
        wb_valid = a_v | m_v;
        wb_rd    = '0;
        wb_data  = '0;
        if (a_v) begin
            wb_rd   = a_rd;
            wb_data = a_d;
        end else if (m_v) begin
            wb_rd   = m_rd;
            wb_data = m_d;
        end
    end

    always_comb begin
        slot_d = slot_q >> 1;
        if (add_push) slot_d[ADD_LAT-1] = 1'b1;
        if (mul_push) slot_d[MUL_LAT-1] = 1'b1;
        pend_d = pend_q & ~wb_clr;
        if (add_push | mul_push) pend_d[rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q  <= 1'b0;
            ill_q  <= 1'b0;
            pend_q <= '0;
            slot_q <= '0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            run_q  <= 1'b1;
            pend_q <= pend_d;
            slot_q <= slot_d;
            if (acc && opcode[2]) ill_q <= 1'b1;
            if (wb_valid) rf_q[wb_rd] <= wb_data;
        end
    end

    assign busy       = (|pend_q) | (|slot_q);
    assign illegal_op = ill_q;
    assign dbg_data   = rf_q[dbg_addr];

endmodule

// File: tb/tb_exwb_sched_pipe.sv
// Self-checking bench for exwb_sched_pipe: architectural model plus timed writeback scoreboard.
module tb_exwb_sched_pipe;

    localparam int ADD_L = 1;
    localparam int MUL_L = 4;
    localparam logic [2:0] T_NOP = 3'b000, T_ADD = 3'b001, T_MUL = 3'b010, T_ADDI = 3'b011;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  opcode = T_NOP;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0, dbg_addr = '0;
    logic [11:0] imm = '0;
    logic        wb_valid, busy, illegal_op;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, dbg_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit sb_on = 1'b1;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } wb_t;
    wb_t sbq[$];
    logic [31:0] mrf [32];

    exwb_sched_pipe #(.WIDTH(32), .NREG(32), .IMM_W(12), .ADD_LAT(ADD_L), .MUL_LAT(MUL_L)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .busy(busy), .illegal_op(illegal_op), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] calc(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [11:0] im);
        logic [63:0] p;
        case (op)
            T_ADD:   return a + b;
            T_ADDI:  return a + {{20{im[11]}}, im};
            T_MUL:   begin p = a * b; return p[31:0]; end
            default: return 32'h0;
        endcase
    endfunction

    // Writeback monitor: each wb must match the entry booked for this exact cycle.
    always @(negedge clk) begin
        int hit;
        int nmiss;
        if (sb_on && rst) begin
            hit = -1;
            total++;
            if (wb_valid) begin
                foreach (sbq[i]) if (hit < 0 && sbq[i].cyc == cyc) hit = i;
                if (hit < 0) begin
                    bad++;
                    $display("FAIL wb_unexpected cyc=%0d got rd=%0d data=%h required no writeback",
                             cyc, wb_rd, wb_data);
                end else begin
                    if (wb_rd !== sbq[hit].rd || wb_data !== sbq[hit].data) begin
                        bad++;
                        $display("FAIL wb_value cyc=%0d got rd=%0d data=%h required rd=%0d data=%h",
                                 cyc, wb_rd, wb_data, sbq[hit].rd, sbq[hit].data);
                    end
                    sbq.delete(hit);
                end
            end else if (wb_rd !== 5'd0 || wb_data !== 32'd0) begin
                bad++;
                $display("FAIL wb_idle_zero cyc=%0d got rd=%0d data=%h required 0/0", cyc, wb_rd, wb_data);
            end
            nmiss = 0;
            for (int i = sbq.size() - 1; i >= 0; i--)
                if (sbq[i].cyc < cyc) begin nmiss++; sbq.delete(i); end
            total++;
            if (nmiss != 0) begin
                bad++;
                $display("FAIL wb_missing cyc=%0d got %0d overdue writebacks required 0", cyc, nmiss);
            end
        end
    end

    // Presents one op at posedge+1 and returns at posedge+1 after it is accepted.
    task automatic issue(input logic [2:0] op, input int d, input int s1, input int s2,
                         input logic [11:0] im, output int acc_cyc);
        int n;
        wb_t e;
        in_valid = 1'b1; opcode = op; rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2); imm = im;
        n = 0;
        acc_cyc = -1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) break;
        end
        total++;
        if (n > 50) begin
            bad++;
            $display("FAIL accept_timeout op=%0d rd=%0d got no accept required accept within 50 cycles", op, d);
            in_valid = 1'b0; opcode = T_NOP;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 1'b0; opcode = T_NOP;
        if (!op[2] && op != T_NOP && d != 0) begin
            e.rd   = 5'(d);
            e.data = calc(op, mrf[s1], mrf[s2], im);
            e.cyc  = acc_cyc + ((op == T_MUL) ? MUL_L : ADD_L) - 1;
            sbq.push_back(e);
            mrf[d] = e.data;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (n > 100) break;
        end
        total++;
        if (n > 100) begin
            bad++;
            $display("FAIL idle_timeout got busy=%0d required 0 within 100 cycles", busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b0 || wb_valid !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0 ||
            busy !== 1'b0 || illegal_op !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got rdy=%b wbv=%b rd=%0d d=%h busy=%b ill=%b required all 0",
                     in_ready, wb_valid, wb_rd, wb_data, busy, illegal_op);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got %b required 1", in_ready);
        end
    endtask

    task automatic test_addi();
        int a;
        issue(T_ADDI, 1, 0, 0, 12'd5, a);
        issue(T_ADDI, 2, 0, 0, 12'hFFD, a);
        wait_idle();
        dbg_addr = 5'd2; #1;
        total++;
        if (dbg_data !== 32'hFFFF_FFFD) begin
            bad++;
            $display("FAIL addi_dbg_r2 got %h required fffffffd", dbg_data);
        end
        dbg_addr = 5'd1; #1;
        total++;
        if (dbg_data !== 32'd5) begin
            bad++;
            $display("FAIL addi_dbg_r1 got %h required 00000005", dbg_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mul_dep();
        int a, m, exp_a;
        issue(T_ADDI, 1, 0, 0, 12'd7, a);
        issue(T_ADDI, 2, 0, 0, 12'd6, a);
        wait_idle();
        issue(T_MUL, 3, 1, 2, 12'd0, m);
        issue(T_ADD, 4, 3, 1, 12'd0, a);
`ifdef EXWB_BYPASS_EN
        exp_a = m + MUL_L;
`else
        exp_a = m + MUL_L + 1;
`endif
        total++;
        if (a !== exp_a) begin
            bad++;
            $display("FAIL raw_accept_cycle got %0d required %0d", a, exp_a);
        end
        wait_idle();
        dbg_addr = 5'd4; #1;
        total++;
        if (dbg_data !== 32'd49) begin
            bad++;
            $display("FAIL raw_dbg_r4 got %h required 00000031", dbg_data);
        end
        dbg_addr = 5'd3; #1;
        total++;
        if (dbg_data !== 32'd42) begin
            bad++;
            $display("FAIL raw_dbg_r3 got %h required 0000002a", dbg_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_slot_conflict();
        int a, m;
        issue(T_MUL, 5, 1, 2, 12'd0, m);
        repeat (MUL_L - ADD_L - 1) @(posedge clk);
        #1;
        issue(T_ADD, 6, 1, 1, 12'd0, a);
        total++;
        if (a !== m + MUL_L - ADD_L + 1) begin
            bad++;
            $display("FAIL slot_stall got accept %0d required %0d", a, m + MUL_L - ADD_L + 1);
        end
        wait_idle();
    endtask

    task automatic test_r0_illegal();
        int a;
        total++;
        if (illegal_op !== 1'b0) begin
            bad++;
            $display("FAIL illegal_pre got %b required 0", illegal_op);
        end
        issue(T_ADD, 0, 1, 2, 12'd0, a);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL r0_busy got %b required 0", busy);
        end
        issue(3'b101, 7, 1, 2, 12'd0, a);
        total++;
        if (illegal_op !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL illegal_flag got ill=%b busy=%b required ill=1 busy=0", illegal_op, busy);
        end
        repeat (6) @(posedge clk);
        #1;
        dbg_addr = 5'd0; #1;
        total++;
        if (dbg_data !== 32'd0) begin
            bad++;
            $display("FAIL r0_zero got %h required 0", dbg_data);
        end
        dbg_addr = 5'd7; #1;
        total++;
        if (dbg_data !== mrf[7]) begin
            bad++;
            $display("FAIL illegal_no_write got %h required %h", dbg_data, mrf[7]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int m;
        issue(T_MUL, 8, 1, 2, 12'd0, m);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
        for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
        #1;
        total++;
        if (in_ready !== 1'b0 || wb_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_outputs got rdy=%b wbv=%b busy=%b required 0/0/0", in_ready, wb_valid, busy);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset_ready got %b required 1", in_ready);
        end
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i); #1;
            total++;
            if (dbg_data !== 32'd0) begin
                bad++;
                $display("FAIL midreset_rf r%0d got %h required 0", i, dbg_data);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int a, sel, d, s1, s2;
        logic [2:0] op;
        for (int n = 0; n < 1000; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      op = T_NOP;
            else if (sel <= 3) op = T_ADD;
            else if (sel <= 5) op = T_MUL;
            else if (sel <= 8) op = T_ADDI;
            else               op = 3'($urandom_range(4, 7));
            d  = $urandom_range(0, 7);
            s1 = $urandom_range(0, 7);
            s2 = $urandom_range(0, 7);
            issue(op, d, s1, s2, 12'($urandom), a);
        end
        wait_idle();
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL random_drain got %0d pending entries required 0", sbq.size());
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 5'(i); #1;
            total++;
            if (dbg_data !== mrf[i]) begin
                bad++;
                $display("FAIL random_rf r%0d got %h required %h", i, dbg_data, mrf[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_mul_dep();
        test_slot_conflict();
        test_r0_illegal();
        test_reset_mid();
        test_back_to_back();
        sb_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
